// File: rtl/if_fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: boot vector, memory size, bubble word and
// controller state encoding used by the fetch, memory and hazard sources.
package if_fetch_ctrl_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam int unsigned DEFAULT_IMEM_BYTES = 4096;
    localparam logic [31:0] DEFAULT_NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Fetch-side bus: the instruction-memory port plus the IF/ID register seen by decode.
interface if_fetch_ctrl_if;

    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    // ifid_valid qualifies ifid_pc/ifid_instr; low means the register holds a bubble.
    logic        ifid_valid;

    modport master (
        output imem_pc,
        input  imem_instr,
        output ifid_pc,
        output ifid_instr,
        output ifid_valid
    );

    modport slave (
        input  imem_pc,
        output imem_instr,
        input  ifid_pc,
        input  ifid_instr,
        input  ifid_valid
    );

endinterface

// File: rtl/if_fetch_ctrl_fetch_addr_check.sv
// Combinational legality test for a fetch address: word aligned and inside imem.
module fetch_addr_check #(
    parameter int unsigned IMEM_BYTES = 4096
) (
    input  logic [31:0] addr,
    output logic        legal
);

    always_comb begin
        legal = (addr[1:0] == 2'b00) && (addr < 32'(IMEM_BYTES));
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, fills IF/ID, applies stall and
// redirect, and halts in a terminal FAULT state on any illegal fetch address.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_BYTES = DEFAULT_IMEM_BYTES,
    parameter logic [31:0] NOP_INSTR  = DEFAULT_NOP_INSTR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    if_fetch_ctrl_if.master      bus,
    output logic                 fault,
    output logic [31:0]          fault_pc,
    output logic                 halted,
    output logic [31:0]          fetch_count,
    output fetch_state_e         dbg_state
);

    fetch_state_e state;
    logic [31:0]  pc_q;
    logic [31:0]  ifid_pc_q;
    logic [31:0]  ifid_instr_q;
    logic         ifid_valid_q;
    logic         pc_legal;
    logic         redirect_legal;

    fetch_addr_check #(.IMEM_BYTES(IMEM_BYTES)) u_pc_check (
        .addr  (pc_q),
        .legal (pc_legal)
    );

    fetch_addr_check #(.IMEM_BYTES(IMEM_BYTES)) u_redirect_check (
        .addr  (redirect_pc),
        .legal (redirect_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_BOOT;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'h0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            fault        <= 1'b0;
            fault_pc     <= 32'h0;
            halted       <= 1'b0;
            fetch_count  <= 32'h0;
        end else begin
            case (state)
                ST_BOOT, ST_RUN: begin
                    // Redirect outranks stall; BOOT handles it exactly like RUN.
                    if (redirect && redirect_legal) begin
                        state        <= ST_RUN;
                        pc_q         <= redirect_pc;
                        ifid_instr_q <= NOP_INSTR;
                        ifid_valid_q <= 1'b0;
                    end else if (redirect) begin
                        state        <= ST_FAULT;
                        fault        <= 1'b1;
                        halted       <= 1'b1;
                        fault_pc     <= redirect_pc;
                        ifid_instr_q <= NOP_INSTR;
                        ifid_valid_q <= 1'b0;
                    end else if (state == ST_BOOT) begin
                        state        <= ST_RUN;
                        ifid_instr_q <= NOP_INSTR;
                        ifid_valid_q <= 1'b0;
                    end else if (stall) begin
                        state <= ST_RUN;
                    end else if (!pc_legal) begin
                        // Catches sequential fall-off past the last word of imem.
                        state        <= ST_FAULT;
                        fault        <= 1'b1;
                        halted       <= 1'b1;
                        fault_pc     <= pc_q;
                        ifid_instr_q <= NOP_INSTR;
                        ifid_valid_q <= 1'b0;
                    end else begin
                        ifid_pc_q    <= pc_q;
                        ifid_instr_q <= bus.imem_instr;
                        ifid_valid_q <= 1'b1;
                        pc_q         <= pc_q + 32'd4;
                        fetch_count  <= fetch_count + 32'd1;
                    end
                end
                ST_FAULT: begin
                    ifid_instr_q <= NOP_INSTR;
                    ifid_valid_q <= 1'b0;
                    fault        <= 1'b1;
                    halted       <= 1'b1;
                end
                default: begin
                    state        <= ST_FAULT;
                    fault        <= 1'b1;
                    halted       <= 1'b1;
                    fault_pc     <= pc_q;
                    ifid_instr_q <= NOP_INSTR;
                    ifid_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_pc    = pc_q;
    assign bus.ifid_pc    = ifid_pc_q;
    assign bus.ifid_instr = ifid_instr_q;
    assign bus.ifid_valid = ifid_valid_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: a combinational program memory model, a
// delivery scoreboard fed by the stimulus, and immediate-assert checks per step.
module tb_if_fetch_ctrl;
    import if_fetch_ctrl_pkg::*;

    logic         clk;
    logic         reset;
    logic         stall;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         fault;
    logic [31:0]  fault_pc;
    logic         halted;
    logic [31:0]  fetch_count;
    fetch_state_e dbg_state;

    if_fetch_ctrl_if bus ();

    if_fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus.master),
        .fault       (fault),
        .fault_pc    (fault_pc),
        .halted      (halted),
        .fetch_count (fetch_count),
        .dbg_state   (dbg_state)
    );

    // ---- clock / reset ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- program memory ----
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: mem_word = 32'h0080_1083;
            32'h0000_0018: mem_word = 32'h0051_0463;
            default:       mem_word = 32'h0000_0013 + {addr[24:0], 7'b0};
        endcase
    endfunction

    always_comb bus.imem_instr = mem_word(bus.imem_pc);

    // ---- scoreboard ----
    logic [63:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_count = 0;
    logic [31:0] last_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({pc, mem_word(pc)});
        exp_count = exp_count + 32'd1;
    endtask

    // A delivery is an increment of fetch_count; each one must match the queue head.
    always @(negedge clk) begin
        if (fetch_count !== last_count) begin
            if (fetch_count === last_count + 32'd1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_delivery_pc", bus.ifid_pc, 32'hxxxx_xxxx);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("sb_ifid_pc", bus.ifid_pc, e[63:32]);
                    chk("sb_ifid_instr", bus.ifid_instr, e[31:0]);
                    chk("sb_ifid_valid", 32'(bus.ifid_valid), 32'd1);
                end
            end
            last_count = fetch_count;
        end
    end

    // ---- driver tasks ----
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_imem_pc"}, bus.imem_pc, 32'h0);
        chk({tag, "_ifid_pc"}, bus.ifid_pc, 32'h0);
        chk({tag, "_ifid_instr"}, bus.ifid_instr, 32'h0000_0013);
        chk({tag, "_ifid_valid"}, 32'(bus.ifid_valid), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_fault_pc"}, fault_pc, 32'h0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_fetch_count"}, fetch_count, 32'h0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(ST_BOOT));
    endtask

    // ---- stimulus ----
    initial begin
        logic [31:0] pc_exp;
        int          n;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        step();
        step();
        chk_reset("por");
        exp_count = 0;
        reset = 1'b0;

        // BOOT bubble, then sequential fetch from 0
        step();
        chk("boot_valid", 32'(bus.ifid_valid), 32'd0);
        chk("boot_instr", bus.ifid_instr, 32'h0000_0013);
        chk("boot_imem_pc", bus.imem_pc, 32'h0);
        push_exp(32'h0);
        step();
        chk("e2_ifid_pc", bus.ifid_pc, 32'h0);
        chk("e2_ifid_instr", bus.ifid_instr, 32'h0080_1083);
        chk("e2_valid", 32'(bus.ifid_valid), 32'd1);
        push_exp(32'h4);
        step();
        chk("e3_ifid_pc", bus.ifid_pc, 32'h4);
        chk("e3_fetch_count", fetch_count, 32'd2);
        chk("e3_imem_pc", bus.imem_pc, 32'h8);

        // Stall held for three cycles at pc 0x8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_ifid_pc", bus.ifid_pc, 32'h4);
            chk("stall_imem_pc", bus.imem_pc, 32'h8);
            chk("stall_count", fetch_count, 32'd2);
        end
        stall = 1'b0;
        push_exp(32'h8);
        step();
        chk("unstall_ifid_pc", bus.ifid_pc, 32'h8);
        chk("unstall_count", fetch_count, 32'd3);

        // Redirect wins over a simultaneous stall
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h18;
        step();
        chk("redir_valid", 32'(bus.ifid_valid), 32'd0);
        chk("redir_instr", bus.ifid_instr, 32'h0000_0013);
        chk("redir_ifid_pc_held", bus.ifid_pc, 32'h8);
        chk("redir_imem_pc", bus.imem_pc, 32'h18);
        chk("redir_count", fetch_count, 32'd3);
        stall = 1'b0; redirect = 1'b0;
        push_exp(32'h18);
        step();
        chk("redir_tgt_pc", bus.ifid_pc, 32'h18);
        chk("redir_tgt_instr", bus.ifid_instr, 32'h0051_0463);

        // Random stall pattern over a short sequential run
        pc_exp = 32'h1C;
        n = $urandom_range(4, 8);
        for (int i = 0; i < n; i++) begin
            stall = 1'($urandom_range(0, 1));
            if (!stall) begin
                push_exp(pc_exp);
                pc_exp = pc_exp + 32'd4;
            end
            step();
            chk("rnd_imem_pc", bus.imem_pc, pc_exp);
            chk("rnd_count", fetch_count, exp_count);
        end
        stall = 1'b0;

        // Misaligned redirect traps; later redirects are ignored
        redirect = 1'b1; redirect_pc = 32'h5;
        step();
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_halted", 32'(halted), 32'd1);
        chk("mis_fault_pc", fault_pc, 32'h5);
        chk("mis_valid", 32'(bus.ifid_valid), 32'd0);
        chk("mis_state", 32'(dbg_state), 32'(ST_FAULT));
        redirect_pc = 32'h0; stall = 1'b1;
        step();
        stall = 1'b0;
        step();
        chk("flt_valid", 32'(bus.ifid_valid), 32'd0);
        chk("flt_imem_pc", bus.imem_pc, pc_exp);
        chk("flt_fault_pc", fault_pc, 32'h5);
        chk("flt_count", fetch_count, exp_count);

        // Reset during FAULT
        reset = 1'b1; redirect = 1'b0;
        step();
        chk_reset("rst_fault");
        exp_count = 0;
        reset = 1'b0;

        // Redirect taken in BOOT to the last legal word, then fall off the end
        redirect = 1'b1; redirect_pc = 32'hFFC;
        step();
        chk("ffc_imem_pc", bus.imem_pc, 32'hFFC);
        chk("ffc_valid", 32'(bus.ifid_valid), 32'd0);
        chk("ffc_state", 32'(dbg_state), 32'(ST_RUN));
        redirect = 1'b0;
        push_exp(32'hFFC);
        step();
        chk("ffc_ifid_pc", bus.ifid_pc, 32'hFFC);
        chk("ffc_ifid_valid", 32'(bus.ifid_valid), 32'd1);
        chk("ffc_next_pc", bus.imem_pc, 32'h1000);
        step();
        chk("oob_fault", 32'(fault), 32'd1);
        chk("oob_fault_pc", fault_pc, 32'h1000);
        chk("oob_halted", 32'(halted), 32'd1);
        chk("oob_valid", 32'(bus.ifid_valid), 32'd0);
        chk("oob_count", fetch_count, 32'd1);

        // Reset during an active stall, then fetch resumes from 0
        reset = 1'b1;
        step();
        exp_count = 0;
        reset = 1'b0;
        step();
        push_exp(32'h0);
        step();
        stall = 1'b1;
        step();
        reset = 1'b1;
        step();
        chk_reset("rst_stall");
        exp_count = 0;
        reset = 1'b0; stall = 1'b0;
        step();
        push_exp(32'h0);
        step();
        chk("resume_pc0", bus.ifid_pc, 32'h0);
        chk("resume_valid", 32'(bus.ifid_valid), 32'd1);
        push_exp(32'h4);
        step();
        chk("resume_pc4", bus.ifid_pc, 32'h4);
        chk("resume_count", fetch_count, 32'd2);

        @(negedge clk);
        #1;
        chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Instruction-fetch controller for the RISC-V core. It owns the PC register and drives the combinational instruction memory (PC in, Instruction_Code out). It captures each fetched word into the IF/ID pipeline register and applies stall and branch-redirect requests from the hazard and branch logic. Illegal fetch addresses (misaligned or ≥ 4 KB) are trapped here, so the core halts instead of silently executing the memory's NOP fill.

Parameters:
RESET_PC, 32'h00000000, PC value after reset
IMEM_BYTES, 4096, instruction memory size in bytes; legal PCs are 0..IMEM_BYTES-4
NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hold PC and IF/ID contents this cycle
redirect  in  1  branch/jump taken; load redirect_pc
redirect_pc  in  32  redirect target byte address
imem_pc  out  32  address to instruction memory, equal to pc_q (combinational)
imem_instr  in  32  Instruction_Code returned by instruction memory, same cycle
ifid_pc  out  32  PC of the instruction held in IF/ID
ifid_instr  out  32  instruction held in IF/ID
ifid_valid  out  1  IF/ID holds a real instruction (0 means bubble)
fault  out  1  sticky fetch fault
fault_pc  out  32  offending address
halted  out  1  controller is in FAULT state
fetch_count  out  32  number of instructions delivered to IF/ID

Behaviour:
- One clock, synchronous active-high reset. Every register updates on the rising clk edge.
- Reset values: pc_q=RESET_PC, state=BOOT, ifid_pc=0, ifid_instr=NOP_INSTR, ifid_valid=0, fault=0, fault_pc=0, halted=0, fetch_count=0.
- Reset has priority over all other inputs. Asserting it mid-stall or mid-redirect restores reset values at the next edge.
- legal(a) is true when a[1:0]==0 and a < IMEM_BYTES.
- States:
  - BOOT: lasts one cycle. IF/ID receives a bubble and pc_q is held. Next state is RUN. If redirect is asserted in BOOT, it is processed exactly as in RUN.
  - RUN: normal fetching, with the priority order below.
  - FAULT: terminal. pc_q and fault_pc are frozen. IF/ID receives a bubble every cycle. stall and redirect are ignored. halted=1 and fault=1. Only reset exits.
- RUN priority, highest first:
  1. redirect=1 and legal(redirect_pc): pc_q<=redirect_pc; IF/ID<=bubble (ifid_instr=NOP_INSTR, ifid_valid=0, ifid_pc unchanged). Penalty is one bubble. Redirect overrides a simultaneous stall.
  2. redirect=1 and !legal(redirect_pc): go to FAULT; fault_pc<=redirect_pc; IF/ID<=bubble.
  3. stall=1: pc_q, IF/ID and fetch_count all hold.
  4. !legal(pc_q): go to FAULT; fault_pc<=pc_q; IF/ID<=bubble. This covers sequential fall-off past IMEM_BYTES-4.
  5. Otherwise: ifid_pc<=pc_q; ifid_instr<=imem_instr; ifid_valid<=1; pc_q<=pc_q+4 (32-bit, wrap ignored); fetch_count<=fetch_count+1.
- fetch_count wraps from 32'hFFFFFFFF to 0.
- Fetch latency: the instruction at address A appears in IF/ID one edge after pc_q==A in a non-stalled RUN cycle.
- No combinational path from stall or redirect to any output except through registers. imem_pc is driven only from pc_q.

Decomposition:
- Shared header riscv_defs: NOP_INSTR, RESET_PC, IMEM_BYTES, and the state encodings ST_BOOT=2'd0, ST_RUN=2'd1, ST_FAULT=2'd2. The same header is used by the inst_mem and hazard-unit sources.
- One natural sub-module: fetch_addr_check, a combinational block computing legal(a). It is instantiated twice, once for pc_q and once for redirect_pc.

Test Plan:
- Reset, then run with the default program:
  - edge 1 after reset release: BOOT, ifid_valid=0, ifid_instr=0x00000013
  - edge 2: ifid_pc=0x0, ifid_instr=0x00801083, ifid_valid=1
  - edge 3: ifid_pc=0x4
  - fetch_count=2 after edge 3
- Stall held 3 cycles while pc_q=0x8 → ifid_pc stays 0x4, imem_pc stays 0x8, fetch_count unchanged. On release, the next edge gives ifid_pc=0x8.
- redirect=1 and stall=1 together with redirect_pc=0x18 → next edge bubble (ifid_valid=0); following edge ifid_pc=0x18, ifid_instr=0x00510463.
- redirect_pc=0x5 → next edge fault=1, halted=1, fault_pc=0x5. Further redirect to 0x0 is ignored; ifid_valid stays 0.
- Redirect to 0xFFC:
  - one edge later, pc_q=0xFFC with IF/ID holding a bubble
  - next edge: ifid_pc=0xFFC valid
  - next edge: fault=1, fault_pc=0x1000
- Reset asserted during FAULT and during an active stall → next edge all outputs at reset values, state BOOT; fetching resumes from 0x0.
